// File: rtl/vending_machine_multi_pkg.sv
// vending_pkg: shared types and helpers for the multi-product vending controller.
//   state_t      - controller state encoding
//   CREDIT_W_DEF - default width of credit/price/change values (cents)
//   coin_value / price_of - pull slice i out of a packed parameter vector
package vending_pkg;

  localparam int CREDIT_W_DEF = 8;
  // Packed parameter vectors are zero-extended to this width before slicing.
  localparam int VEC_W = 256;

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, ERROR} state_t;

  function automatic logic [31:0] slice_of(input logic [VEC_W-1:0] vec, input int idx, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (idx * w)) & mask;
  endfunction

  function automatic logic [31:0] coin_value(input logic [VEC_W-1:0] coin_values, input int idx, input int w);
    return slice_of(coin_values, idx, w);
  endfunction

  function automatic logic [31:0] price_of(input logic [VEC_W-1:0] prices, input int idx, input int w);
    return slice_of(prices, idx, w);
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Board-side bundle of the vending controller.
//   btn_coin/btn_select/btn_cancel : raw active-high push-buttons
//   credit, dispense, change_valid, change_amount, coin_reject : actuator/display
//   led_ready/led_busy/led_done/led_error : status LEDs
// master = board/stimulus side, slave = controller side.
interface vending_machine_multi_if
  import vending_pkg::*;
#(
  parameter int N_COIN   = 3,
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = CREDIT_W_DEF
);
  logic [N_COIN-1:0]   btn_coin;
  logic [N_PROD-1:0]   btn_select;
  logic                btn_cancel;
  logic [CREDIT_W-1:0] credit;
  logic [N_PROD-1:0]   dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic                coin_reject;
  logic                led_ready;
  logic                led_busy;
  logic                led_done;
  logic                led_error;

  modport master (
    output btn_coin, btn_select, btn_cancel,
    input  credit, dispense, change_valid, change_amount, coin_reject,
    input  led_ready, led_busy, led_done, led_error
  );

  modport slave (
    input  btn_coin, btn_select, btn_cancel,
    output credit, dispense, change_valid, change_amount, coin_reject,
    output led_ready, led_busy, led_done, led_error
  );
endinterface

// File: rtl/vending_machine_multi_btn_conditioner.sv
// btn_conditioner: one raw button -> 2-flop synchroniser -> debouncer ->
// single-cycle rising-edge pulse. Pulse appears 2 + DEBOUNCE_CYCLES + 1 cycles
// after the raw edge; a held button gives exactly one pulse.
//   clk50, rst_n : clock, async active-low reset
//   raw          : asynchronous button level
//   pulse        : one-cycle press event
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a, sync_b;
  logic             stable, stable_q;
  logic [CNT_W-1:0] cnt;

  // Down-counter reloads whenever the synchronised level agrees with the
  // accepted level; it must run out while they disagree for a change to stick.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync_a   <= raw;
      sync_b   <= sync_a;
      stable_q <= stable;
      pulse    <= stable & ~stable_q;
      if (sync_b == stable) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        stable <= sync_b;
        cnt    <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-coin, multi-product vending controller.
//   clk50 : 50 MHz board clock
//   rst_n : async active-low reset
//   bus   : buttons in, credit/dispense/change/reject strobes and LEDs out
//
// state    | meaning
// IDLE     | no credit, waiting for a coin
// CREDIT   | credit held; coins add, select buys, cancel/timeout refund
// DISPENSE | product one-hot held for DISPENSE_CYCLES, then change strobe
// ERROR    | error LED for ERR_CYCLES, then back to CREDIT or IDLE
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                         N_COIN          = 3,
  parameter int                         N_PROD          = 4,
  parameter int                         CREDIT_W        = CREDIT_W_DEF,
  parameter logic [N_COIN*CREDIT_W-1:0] COIN_VALUES     = {8'd25, 8'd10, 8'd5},
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES          = {8'd75, 8'd50, 8'd35, 8'd25},
  parameter int                         MAX_CREDIT      = 200,
  parameter int                         DEBOUNCE_CYCLES = 500000,
  parameter int                         DISPENSE_CYCLES = 50000000,
  parameter int                         ERR_CYCLES      = 25000000,
  parameter int                         TIMEOUT_CYCLES  = 1500000000
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  vending_machine_multi_if.slave bus
);
  localparam int N_BTN = N_COIN + N_PROD + 1;
  localparam logic [VEC_W-1:0] COIN_EXT  = VEC_W'(COIN_VALUES);
  localparam logic [VEC_W-1:0] PRICE_EXT = VEC_W'(PRICES);
  localparam logic [31:0] DISP_LOAD = 32'(DISPENSE_CYCLES - 1);
  localparam logic [31:0] ERR_LOAD  = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  logic [CREDIT_W-1:0] coin_tbl  [N_COIN];
  logic [CREDIT_W-1:0] price_tbl [N_PROD];

  if (MAX_CREDIT > (2**CREDIT_W) - 1) begin : g_bad_max
    $fatal(1, "MAX_CREDIT does not fit in CREDIT_W bits");
  end
  for (genvar i = 0; i < N_COIN; i++) begin : g_coin
    if (int'(coin_value(COIN_EXT, i, CREDIT_W)) > MAX_CREDIT) begin : g_bad
      $fatal(1, "coin value exceeds MAX_CREDIT");
    end
    assign coin_tbl[i] = CREDIT_W'(coin_value(COIN_EXT, i, CREDIT_W));
  end
  for (genvar i = 0; i < N_PROD; i++) begin : g_price
    if (price_of(PRICE_EXT, i, CREDIT_W) == 32'd0) begin : g_bad
      $fatal(1, "product price of zero");
    end
    assign price_tbl[i] = CREDIT_W'(price_of(PRICE_EXT, i, CREDIT_W));
  end

  logic [N_BTN-1:0]  raw_btn, ev;
  logic [N_COIN-1:0] ev_coin;
  logic [N_PROD-1:0] ev_sel;
  logic              ev_cancel;

  assign raw_btn   = {bus.btn_cancel, bus.btn_select, bus.btn_coin};
  assign ev_coin   = ev[N_COIN-1:0];
  assign ev_sel    = ev[N_COIN +: N_PROD];
  assign ev_cancel = ev[N_BTN-1];

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk50 (clk50),
      .rst_n (rst_n),
      .raw   (raw_btn[b]),
      .pulse (ev[b])
    );
  end

  // Lowest index wins within each group; iterate high-to-low so the last hit sticks.
  logic                coin_hit, sel_hit;
  logic [CREDIT_W-1:0] coin_val, price;
  logic [N_PROD-1:0]   sel_oh;

  always_comb begin
    coin_hit = 1'b0;
    coin_val = '0;
    for (int i = N_COIN - 1; i >= 0; i--) begin
      if (ev_coin[i]) begin
        coin_hit = 1'b1;
        coin_val = coin_tbl[i];
      end
    end
    sel_hit = 1'b0;
    sel_oh  = '0;
    price   = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (ev_sel[i]) begin
        sel_hit   = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        price     = price_tbl[i];
      end
    end
  end

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n, change_q, change_n, ca_q, ca_n;
  logic [N_PROD-1:0]   disp_q, disp_n;
  logic                cv_q, cv_n, rej_q, rej_n;
  logic [31:0]         tmr, tmr_n;
  logic [CREDIT_W:0]   sum;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      ca_q     <= '0;
      disp_q   <= '0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      tmr      <= '0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      change_q <= change_n;
      ca_q     <= ca_n;
      disp_q   <= disp_n;
      cv_q     <= cv_n;
      rej_q    <= rej_n;
      tmr      <= tmr_n;
    end
  end

  // One shared down-counter times dispense, error and inactivity.
  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    change_n = change_q;
    disp_n   = disp_q;
    tmr_n    = (tmr != '0) ? tmr - 32'd1 : tmr;
    cv_n     = 1'b0;
    ca_n     = '0;
    rej_n    = 1'b0;
    sum      = {1'b0, credit_q} + {1'b0, coin_val};
    case (state)
      IDLE: begin
        if (!ev_cancel) begin
          if (sel_hit) begin
            state_n = ERROR;
            tmr_n   = ERR_LOAD;
          end else if (coin_hit) begin
            state_n  = CREDIT;
            credit_n = coin_val;
            tmr_n    = TMO_LOAD;
          end
        end
      end
      CREDIT: begin
        if (ev_cancel || sel_hit || coin_hit) tmr_n = TMO_LOAD;
        if (ev_cancel || (!sel_hit && !coin_hit && tmr == '0)) begin
          state_n  = IDLE;
          cv_n     = 1'b1;
          ca_n     = credit_q;
          credit_n = '0;
        end else if (sel_hit) begin
          if (credit_q >= price) begin
            state_n  = DISPENSE;
            disp_n   = sel_oh;
            change_n = credit_q - price;
            tmr_n    = DISP_LOAD;
          end else begin
            state_n = ERROR;
            tmr_n   = ERR_LOAD;
          end
        end else if (coin_hit) begin
          if (sum <= MAX_SUM) credit_n = sum[CREDIT_W-1:0];
          else                rej_n    = 1'b1;
        end
      end
      DISPENSE: begin
        if (tmr == '0) begin
          state_n  = IDLE;
          disp_n   = '0;
          credit_n = '0;
          cv_n     = 1'b1;
          ca_n     = change_q;
        end
      end
      ERROR: begin
        if (tmr == '0) begin
          state_n = (credit_q != '0) ? CREDIT : IDLE;
          tmr_n   = TMO_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.credit        = credit_q;
  assign bus.dispense      = disp_q;
  assign bus.change_valid  = cv_q;
  assign bus.change_amount = ca_q;
  assign bus.coin_reject   = rej_q;
  assign bus.led_ready     = (state == IDLE);
  assign bus.led_busy      = (state == CREDIT) || (state == DISPENSE);
  assign bus.led_done      = (state == DISPENSE);
  assign bus.led_error     = (state == ERROR);
endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi with short timing parameters.
module tb_vending_machine_multi;
  localparam int K_CRED = 0, K_CHG = 1, K_REJ = 2, K_DISP = 3, K_DLEN = 4, K_ERR = 5, K_ELEN = 6;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk50 = ~clk50;

  vending_machine_multi_if #(.N_COIN(3), .N_PROD(4), .CREDIT_W(8)) bus ();

  vending_machine_multi #(
    .DEBOUNCE_CYCLES (4),
    .DISPENSE_CYCLES (10),
    .ERR_CYCLES      (6),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int kind; int val;} exp_t;
  exp_t  exp_q[$];
  string kname[7] = '{"credit", "change", "reject", "dispense", "disp_len", "error", "err_len"};
  int    coin_v[3] = '{5, 10, 25};
  int    price[4]  = '{25, 35, 50, 75};

  int n_checks = 0, n_fail = 0, cyc = 0;
  int cred_cyc = 0, chg_cyc = 0;
  bit done_seen = 0, busy_seen = 0;
  bit m_active = 0;
  int m_credit = 0;

  always @(posedge clk50) cyc <= cyc + 1;

  function automatic void push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_obs(input int k, input int v);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %s=%0d expected nothing", kname[k], v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL scoreboard: got %s=%0d expected %s=%0d", kname[k], v, kname[e.kind], e.val);
      end
    end
  endtask

  // Reference model: one decision per press from the pricing rules.
  task automatic model_refund();
    if (m_active) begin
      push(K_CHG, m_credit);
      push(K_CRED, 0);
      m_active = 0;
      m_credit = 0;
    end
  endtask

  task automatic model_press(input logic [2:0] cm, input logic [3:0] sm, input logic cn);
    int p, c;
    if (cn) begin
      model_refund();
    end else if (sm != 0) begin
      p = 0;
      for (int i = 3; i >= 0; i--) if (sm[i]) p = i;
      if (m_active && m_credit >= price[p]) begin
        push(K_DISP, 1 << p);
        push(K_DLEN, 10);
        push(K_CHG, m_credit - price[p]);
        push(K_CRED, 0);
        m_active = 0;
        m_credit = 0;
      end else begin
        push(K_ERR, 1);
        push(K_ELEN, 6);
      end
    end else if (cm != 0) begin
      c = 0;
      for (int i = 2; i >= 0; i--) if (cm[i]) c = i;
      if (!m_active) begin
        m_active = 1;
        m_credit = coin_v[c];
        push(K_CRED, m_credit);
      end else if (m_credit + coin_v[c] <= 200) begin
        m_credit += coin_v[c];
        push(K_CRED, m_credit);
      end else begin
        push(K_REJ, 0);
      end
    end
  endtask

  task automatic press(input logic [2:0] cm, input logic [3:0] sm, input logic cn);
    model_press(cm, sm, cn);
    bus.btn_coin   = cm;
    bus.btn_select = sm;
    bus.btn_cancel = cn;
    repeat (8) @(negedge clk50);
    bus.btn_coin   = '0;
    bus.btn_select = '0;
    bus.btn_cancel = 1'b0;
    repeat (10) @(negedge clk50);
    if (sm != 0 && !cn) repeat (20) @(negedge clk50);
  endtask

  // Monitor: turns DUT activity into observations, fixed order within a cycle.
  initial begin
    logic [3:0] pd;
    bit         pe;
    int         pc, ds, es;
    pd = '0; pe = 0; pc = 0; ds = 0; es = 0;
    forever begin
      @(negedge clk50);
      if (!rst_n) begin
        pd = '0; pe = 0; pc = 0;
      end else begin
        if (bus.dispense != 0 && pd == 0) begin
          ds = cyc;
          done_seen = bus.led_done;
          busy_seen = bus.led_busy;
          sb_obs(K_DISP, int'(bus.dispense));
        end
        if (bus.dispense == 0 && pd != 0) sb_obs(K_DLEN, cyc - ds);
        if (bus.led_error && !pe) begin
          es = cyc;
          sb_obs(K_ERR, 1);
        end
        if (!bus.led_error && pe) sb_obs(K_ELEN, cyc - es);
        if (bus.coin_reject) sb_obs(K_REJ, 0);
        if (bus.change_valid) begin
          chg_cyc = cyc;
          sb_obs(K_CHG, int'(bus.change_amount));
        end
        if (int'(bus.credit) != pc) begin
          cred_cyc = cyc;
          sb_obs(K_CRED, int'(bus.credit));
        end
        pd = bus.dispense;
        pe = bus.led_error;
        pc = int'(bus.credit);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    bus.btn_coin   = '0;
    bus.btn_select = '0;
    bus.btn_cancel = 1'b0;
    repeat (3) @(negedge clk50);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_dispense", int'(bus.dispense), 0);
    chk("rst_led_ready", int'(bus.led_ready), 1);
    chk("rst_led_busy", int'(bus.led_busy), 0);
    chk("rst_led_error", int'(bus.led_error), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);

    // 25+25+25, buy product 3 at 75 -> zero change
    repeat (3) press(3'b100, 4'b0, 1'b0);
    press(3'b000, 4'b1000, 1'b0);
    chk("led_done_in_dispense", int'(done_seen), 1);
    chk("led_busy_in_dispense", int'(busy_seen), 1);
    chk("ready_after_buy", int'(bus.led_ready), 1);

    // 25+25+10, buy product 1 at 35 -> change 25
    press(3'b100, 4'b0, 1'b0);
    press(3'b100, 4'b0, 1'b0);
    press(3'b010, 4'b0, 1'b0);
    press(3'b000, 4'b0010, 1'b0);
    chk("credit_after_buy", int'(bus.credit), 0);

    // 5 then product 3 -> error, credit kept, then cancel
    press(3'b001, 4'b0, 1'b0);
    press(3'b000, 4'b1000, 1'b0);
    chk("credit_after_error", int'(bus.credit), 5);
    chk("busy_after_error", int'(bus.led_busy), 1);
    press(3'b000, 4'b0, 1'b1);

    // build 190, reject 25, accept 10 -> 200
    repeat (7) press(3'b100, 4'b0, 1'b0);
    press(3'b010, 4'b0, 1'b0);
    press(3'b001, 4'b0, 1'b0);
    press(3'b100, 4'b0, 1'b0);
    chk("credit_after_reject", int'(bus.credit), 190);
    press(3'b010, 4'b0, 1'b0);
    chk("credit_at_max", int'(bus.credit), 200);
    press(3'b000, 4'b0, 1'b1);

    // inactivity refund of 10 exactly 50 cycles after the credit update
    press(3'b010, 4'b0, 1'b0);
    t0 = cred_cyc;
    model_refund();
    n = 0;
    while (chg_cyc <= t0 && n < 100) begin
      @(negedge clk50);
      n++;
    end
    chk("timeout_gap", chg_cyc - t0, 50);
    repeat (2) @(negedge clk50);
    chk("ready_after_timeout", int'(bus.led_ready), 1);

    // 2-cycle glitch is filtered
    bus.btn_coin = 3'b100;
    repeat (2) @(negedge clk50);
    bus.btn_coin = 3'b000;
    repeat (20) @(negedge clk50);
    chk("glitch_credit", int'(bus.credit), 0);

    // coin[0] and coin[2] together -> coin 0 (5) wins
    press(3'b101, 4'b0, 1'b0);
    chk("simul_coin_credit", int'(bus.credit), 5);
    press(3'b000, 4'b0, 1'b1);

    // reset in the middle of a dispense
    press(3'b100, 4'b0, 1'b0);
    push(K_DISP, 1);
    bus.btn_select = 4'b0001;
    n = 0;
    while (bus.dispense == 0 && n < 40) begin
      @(negedge clk50);
      n++;
    end
    chk("dispense_started", int'(bus.dispense != 0), 1);
    bus.btn_select = 4'b0000;
    repeat (3) @(negedge clk50);
    rst_n = 1'b0;
    #1;
    chk("abort_credit", int'(bus.credit), 0);
    chk("abort_dispense", int'(bus.dispense), 0);
    chk("abort_change_valid", int'(bus.change_valid), 0);
    chk("abort_led_ready", int'(bus.led_ready), 1);
    chk("abort_led_done", int'(bus.led_done), 0);
    m_active = 0;
    m_credit = 0;
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    repeat (30) @(negedge clk50);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      int a;
      a = $urandom_range(0, 8);
      if (a <= 4)      press(3'($urandom_range(1, 7)), 4'b0, 1'b0);
      else if (a <= 6) press(3'($urandom_range(0, 7)), 4'($urandom_range(1, 15)), 1'b0);
      else if (a == 7) press(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1);
      else begin
        model_refund();
        repeat (60) @(negedge clk50);
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk50);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product vending controller: several coin denominations, several products with individual prices, credit accumulation, cancel/refund, change return, inactivity timeout.
- Sits under the board top, clocked by the 50 MHz board clock. Takes raw push-buttons and drives status LEDs plus dispense and change strobes for the downstream actuator and display logic.

Parameters:
- N_COIN, 3, number of coin buttons/denominations.
- N_PROD, 4, number of products.
- CREDIT_W, 8, width of credit, price and change values, in cents.
- COIN_VALUES, {8'd25,8'd10,8'd5}, packed N_COIN*CREDIT_W; slice i is the value of coin i.
- PRICES, {8'd75,8'd50,8'd35,8'd25}, packed N_PROD*CREDIT_W; slice i is the price of product i.
- MAX_CREDIT, 200, highest credit accepted; must be at most 2^CREDIT_W-1.
- DEBOUNCE_CYCLES, 500000, cycles a button must be stable (10 ms at 50 MHz).
- DISPENSE_CYCLES, 50000000, length of the dispense phase.
- ERR_CYCLES, 25000000, length of the error-LED indication.
- TIMEOUT_CYCLES, 1500000000, inactivity limit in CREDIT before auto-refund.

Ports:
- clk50  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_coin  input  N_COIN  raw coin buttons, active-high.
- btn_select  input  N_PROD  raw product buttons, active-high.
- btn_cancel  input  1  raw cancel/refund button, active-high.
- credit  output  CREDIT_W  current credit.
- dispense  output  N_PROD  one-hot; held for the whole dispense phase.
- change_valid  output  1  one-cycle strobe.
- change_amount  output  CREDIT_W  change value; valid while change_valid is high, 0 otherwise.
- coin_reject  output  1  one-cycle strobe when a coin would exceed MAX_CREDIT.
- led_ready  output  1  high in IDLE.
- led_busy  output  1  high in CREDIT or DISPENSE.
- led_done  output  1  high in DISPENSE.
- led_error  output  1  high in ERROR.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, credit=0, all strobes and dispense=0, led_ready=1, all other LEDs 0, all debounce and timer counters cleared. Reset mid-dispense aborts the dispense with no change output.
- Button input path: every button passes through a 2-flop synchroniser, then a debouncer, then a rising-edge detector. This yields a single-cycle event per press. Event latency from raw edge = 2 + DEBOUNCE_CYCLES + 1 cycles. Holding a button produces no repeat events.
- At most one event is acted on per cycle. Priority is cancel > select > coin. Among several selects, the lowest index wins; the same rule applies among coins. Losing events are dropped, not queued.
- State IDLE:
  - A coin event for coin i moves to CREDIT with credit=COIN_VALUES[i].
  - A select event moves to ERROR.
  - A cancel event is ignored.
- State CREDIT:
  - Coin event: if credit+value <= MAX_CREDIT, credit adds the value. Otherwise credit is unchanged and coin_reject pulses. The sum is computed at CREDIT_W+1 bits, so there is no wrap.
  - Select event for product p: if credit >= PRICES[p], go to DISPENSE, set dispense[p]=1 and latch change = credit - PRICES[p]. Otherwise go to ERROR with credit kept.
  - Cancel event: change_valid=1 and change_amount=credit for one cycle, credit becomes 0, go to IDLE.
  - Inactivity timer: resets on any event and counts otherwise. When it reaches TIMEOUT_CYCLES-1, perform the same refund as cancel.
- State DISPENSE:
  - Lasts exactly DISPENSE_CYCLES cycles. All events are ignored.
  - On the last cycle: dispense=0, credit=0, change_valid pulses with the latched change (pulses even when the change is 0), go to IDLE.
- State ERROR:
  - Lasts exactly ERR_CYCLES cycles. Events are ignored.
  - Then returns to CREDIT if credit>0, else to IDLE. Credit is preserved.
- credit output is registered and updates in the cycle after the event.
- Elaboration checks on parameters: any price of 0, or any coin value > MAX_CREDIT, is a fatal error.

Decomposition:
- Package vending_pkg holds:
  - state enum {IDLE, CREDIT, DISPENSE, ERROR};
  - a default CREDIT_W constant;
  - helper functions to extract slice i from COIN_VALUES and PRICES.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES) does synchronise, debounce and rising-edge pulse for one button. It is instantiated N_COIN+N_PROD+1 times with a generate loop.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, DISPENSE_CYCLES=10, ERR_CYCLES=6, TIMEOUT_CYCLES=50.
- Coin 25 three times, then select product 3 (price 75) -> credit 25/50/75; dispense=4'b1000 for 10 cycles, led_done=1; then change_valid pulse with amount 0; IDLE.
- Coins 25+25+10, then select product 1 (price 35) -> dispense[1]=1; change_amount=25; credit 0 afterwards.
- Coin 5, then select product 3 -> led_error high for 6 cycles; returns to CREDIT with credit=5. Then cancel -> change_amount=5, IDLE.
- Credit 190, then coin 25 -> coin_reject pulse, credit stays 190. Then coin 10 -> credit 200.
- Coin 10, then no activity -> after 50 cycles, change_valid with amount 10; led_ready=1.
- Glitches and edge cases:
  - a 2-cycle glitch on btn_coin -> no credit change;
  - simultaneous coin[0] and coin[2] -> credit 5;
  - rst_n low mid-DISPENSE -> all outputs at reset values immediately, no change strobe.
